// File: rtl/l2_cmd_pkg.sv
// Shared layer-2 definitions: FSM state encodings, header length and gap timing.
package l2_cmd_pkg;

    // Command header is always CLA, INS, P1, P2, P3.
    localparam int unsigned L2_NBYTES  = 5;
    // Idle gap after each accepted byte; the response block waits the same 8 cycles.
    localparam int unsigned L2_GAP_CYC = 8;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [6:0] {
        StIdle = 7'b000_0001,
        StW0   = 7'b000_0010,
        StW1   = 7'b000_0100,
        StSend = 7'b000_1000,
        StGap  = 7'b001_0000,
        StDone = 7'b010_0000,
        StErr  = 7'b100_0000
    } l2_cmd_state_e;

endpackage

// File: rtl/l2_cmd.sv
// Layer-2 command sender: latches a 5-byte header on l3_en and hands it byte by byte
// to the lower layer, with a fixed idle gap after each accepted byte.
module l2_cmd
    import l2_cmd_pkg::*;
#(
    parameter int unsigned GAP_CYC = L2_GAP_CYC,
    parameter int unsigned NBYTES  = L2_NBYTES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pin_l2_clr,
    input  logic       l3_en,
    input  logic       l3_cmd_done,
    input  logic       err_timeout,
    input  logic [7:0] cla,
    input  logic [7:0] ins,
    input  logic [7:0] p1,
    input  logic [7:0] p2,
    input  logic [7:0] p3,
    output logic [7:0] cmd,
    output logic       cmd_vld,
    input  logic       cmd_rdy,
    output logic       cmd_done,
    output logic       cmd_err,
    output logic       cmd_busy
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    l2_cmd_state_e    state_q;
    logic [7:0]       hdr_q [NBYTES];
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] gap_q;

    // Sequencer: reset beats clear, clear beats every state transition including a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            gap_q   <= '0;
            for (int i = 0; i < int'(NBYTES); i++) begin
                hdr_q[i] <= '0;
            end
        end else if (pin_l2_clr) begin
            state_q <= StIdle;
            idx_q   <= '0;
            gap_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (l3_en) begin
                        hdr_q[0] <= cla;
                        hdr_q[1] <= ins;
                        hdr_q[2] <= p1;
                        hdr_q[3] <= p2;
                        hdr_q[4] <= p3;
                        idx_q    <= '0;
                        state_q  <= StW0;
                    end
                end
                StW0: state_q <= StW1;
                StW1: state_q <= StSend;
                StSend: begin
                    // A handshake in the same cycle as a timeout still counts as delivered.
                    if (cmd_rdy) begin
                        idx_q   <= idx_q + IDX_W'(1);
                        gap_q   <= '0;
                        state_q <= StGap;
                    end else if (err_timeout) begin
                        state_q <= StErr;
                    end
                end
                StGap: begin
                    if (gap_q == GAP_LAST) begin
                        gap_q   <= '0;
                        state_q <= (idx_q == IDX_LAST) ? StDone : StSend;
                    end else begin
                        gap_q <= gap_q + CNT_W'(1);
                    end
                end
                StDone: if (l3_cmd_done) state_q <= StIdle;
                StErr:  if (l3_cmd_done) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Status outputs depend only on the state register, never on inputs.
    always_comb begin
        cmd_vld  = (state_q == StSend);
        cmd_done = (state_q == StDone);
        cmd_err  = (state_q == StErr);
        cmd_busy = (state_q != StIdle);
        cmd      = cmd_vld ? hdr_q[idx_q] : 8'h00;
    end

endmodule
